// File: rtl/pll_mdrp_ctrl.sv
// ---------------------------------------------------------------------------
// PllMdrpCtrl -- host-side controller for a PLL MDRP configuration port.
//
// A host request (read or write of one 7-bit PLL register) is turned into a
// sequence of MDRP cycles. The PLL keeps an internal address pointer that can
// only be reset to zero or incremented by one. This controller shadows that
// pointer so it can skip the reset/increment steps when possible.
//
// Each MDRP cycle lasts 2*CLK_DIV clk cycles. mdclk is low for the first
// CLK_DIV cycles and high for the last CLK_DIV cycles. The PLL samples on the
// rising edge of mdclk.
//
// Ports
//   clk        : system clock; the only clock
//   resetn     : synchronous, active-low reset
//   cmd_valid  : host request valid
//   cmd_ready  : high only while idle; a request is taken on valid && ready
//   cmd_write  : 1 = write, 0 = read
//   cmd_addr   : PLL register address
//   cmd_wdata  : write data
//   rsp_valid  : one-cycle completion pulse
//   rsp_rdata  : read data, 0x00 after a write; held until the next response
//   mdclk      : PLL configuration clock
//   mdopc      : opcode 00 NOP, 01 WRITE, 10 READ, 11 ADDR_RESET
//   mdainc     : pointer increment, only used together with NOP
//   mdwdi      : write data to the PLL
//   mdrdo      : read data from the PLL
// ---------------------------------------------------------------------------
module pll_mdrp_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       mdclk,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo
);

    typedef enum logic [2:0] {
        IDLE,
        ARST,
        AINC,
        OP,
        RDWAIT,
        RESP
    } state_t;

    localparam logic [8:0] HALF = 9'(CLK_DIV);
    localparam logic [8:0] FULL = 9'(2 * CLK_DIV);

    state_t     state_q;
    state_t     state_d;
    logic [6:0] ptr_q;
    logic [6:0] ptr_d;
    logic       ptrOk_q;
    logic [8:0] cnt_q;
    logic       write_q;
    logic [6:0] addr_q;
    logic [7:0] wdata_q;
    logic       cmdReady_q;
    logic       rspValid_q;
    logic [7:0] rspRdata_q;
    logic       mdclk_q;
    logic [1:0] mdopc_q;
    logic       mdainc_q;
    logic [7:0] mdwdi_q;

    // Opcode, increment flag and write data presented for one MDRP cycle
    // issued from the given state, packed as {mdopc, mdainc, mdwdi}.
    function automatic logic [10:0] cycleFields(input state_t s, input logic wr,
                                                input logic [7:0] wd);
        logic [10:0] f;
        f = {2'b00, 1'b0, 8'h00};
        case (s)
            ARST:    f = {2'b11, 1'b0, 8'h00};
            AINC:    f = {2'b00, 1'b1, 8'h00};
            OP:      f = wr ? {2'b01, 1'b0, wd} : {2'b10, 1'b0, 8'h00};
            RDWAIT:  f = {2'b00, 1'b0, 8'h00};
            default: f = {2'b00, 1'b0, 8'h00};
        endcase
        return f;
    endfunction

    // Where the FSM goes, and what the shadow pointer becomes, once the
    // MDRP cycle of the current state has finished.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARST: begin
                ptr_d   = 7'd0;
                state_d = (addr_q == 7'd0) ? OP : AINC;
            end
            AINC: begin
                ptr_d   = ptr_q + 7'd1;
                state_d = (ptr_d == addr_q) ? OP : AINC;
            end
            OP:      state_d = write_q ? RESP : RDWAIT;
            RDWAIT:  state_d = RESP;
            default: state_d = state_q;
        endcase
    end

    // Main FSM. cnt_q == 0 marks an operation state that has not started its
    // first MDRP cycle yet; this costs one clk after accept. Back-to-back MDRP
    // cycles then chain without gaps. cnt_q counts clk edges since the cycle
    // began: mdclk rises at HALF and the cycle ends at FULL.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ptr_q      <= 7'd0;
            ptrOk_q    <= 1'b0;
            cnt_q      <= 9'd0;
            write_q    <= 1'b0;
            addr_q     <= 7'd0;
            wdata_q    <= 8'h00;
            cmdReady_q <= 1'b0;
            rspValid_q <= 1'b0;
            rspRdata_q <= 8'h00;
            mdclk_q    <= 1'b0;
            mdopc_q    <= 2'b00;
            mdainc_q   <= 1'b0;
            mdwdi_q    <= 8'h00;
        end else begin
            rspValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmdReady_q) begin
                        write_q    <= cmd_write;
                        addr_q     <= cmd_addr;
                        wdata_q    <= cmd_wdata;
                        cmdReady_q <= 1'b0;
                        cnt_q      <= 9'd0;
                        if (!ptrOk_q || (cmd_addr < ptr_q)) begin
                            state_q <= ARST;
                        end else if (cmd_addr > ptr_q) begin
                            state_q <= AINC;
                        end else begin
                            state_q <= OP;
                        end
                    end else begin
                        cmdReady_q <= 1'b1;
                    end
                end
                ARST, AINC, OP, RDWAIT: begin
                    if (cnt_q == 9'd0) begin
                        {mdopc_q, mdainc_q, mdwdi_q} <= cycleFields(state_q, write_q, wdata_q);
                        mdclk_q <= 1'b0;
                        cnt_q   <= 9'd1;
                    end else if (cnt_q == FULL) begin
                        ptr_q   <= ptr_d;
                        state_q <= state_d;
                        if (state_q == ARST) begin
                            ptrOk_q <= 1'b1;
                        end
                        mdclk_q <= 1'b0;
                        if (state_d == RESP) begin
                            // Read data is taken as the NOP cycle's high phase ends.
                            rspRdata_q <= (state_q == RDWAIT) ? mdrdo : 8'h00;
                            rspValid_q <= 1'b1;
                            mdopc_q    <= 2'b00;
                            mdainc_q   <= 1'b0;
                            cnt_q      <= 9'd0;
                        end else begin
                            {mdopc_q, mdainc_q, mdwdi_q} <= cycleFields(state_d, write_q, wdata_q);
                            cnt_q <= 9'd1;
                        end
                    end else begin
                        if (cnt_q == HALF) begin
                            mdclk_q <= 1'b1;
                        end
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    cmdReady_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmdReady_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign mdclk     = mdclk_q;
    assign mdopc     = mdopc_q;
    assign mdainc    = mdainc_q;
    assign mdwdi     = mdwdi_q;

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_mdrp_ctrl -- self-checking bench for pll_mdrp_ctrl (CLK_DIV = 2).
//
// A behavioural PLL register file sits on the MDRP side and reacts to the
// rising edge of mdclk. A transaction-level reference (a register array, the
// pointer position and whether it is known) predicts latency, step counts and
// read data from the request sequence alone.
// ---------------------------------------------------------------------------
module tb_pll_mdrp_ctrl;

    localparam int CLK_DIV = 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       mdclk;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo;

    int compCount = 0;
    int failCount = 0;

    // PLL-side model state
    logic [7:0] pllMem [128];
    logic [6:0] pllPtr;
    logic [7:0] pllRdo;
    int         cntArst;
    int         cntAinc;
    int         cntWr;
    int         cntRd;
    int         cntNop;

    // Transaction-level reference
    logic [7:0] refMem [128];
    logic [6:0] refPtr;
    logic       refPtrOk;

    // MDRP-cycle shape monitor history
    logic        skipMon = 1'b1;
    logic        pClk1 = 1'b0;
    logic [10:0] pVal1 = '0;
    logic [10:0] pVal2 = '0;
    int          highRun = 0;

    pll_mdrp_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mdclk     (mdclk),
        .mdopc     (mdopc),
        .mdainc    (mdainc),
        .mdwdi     (mdwdi),
        .mdrdo     (mdrdo)
    );

    always #5 clk = ~clk;

    assign mdrdo = pllRdo;

    // Power-on contents of the PLL registers; address 5 holds 0xC3.
    function automatic logic [7:0] initVal(input logic [6:0] a);
        return (a == 7'd5) ? 8'hC3 : 8'(a * 29 + 1);
    endfunction

    // The PLL itself: acts on each rising edge of mdclk.
    initial begin
        for (int a = 0; a < 128; a++) pllMem[a] = initVal(7'(a));
        pllPtr  = 7'd0;
        pllRdo  = 8'h00;
        cntArst = 0;
        cntAinc = 0;
        cntWr   = 0;
        cntRd   = 0;
        cntNop  = 0;
        forever begin
            @(posedge mdclk);
            case (mdopc)
                2'b11: begin
                    pllPtr = 7'd0;
                    cntArst++;
                end
                2'b00: begin
                    if (mdainc) begin
                        pllPtr = pllPtr + 7'd1;
                        cntAinc++;
                    end else begin
                        cntNop++;
                    end
                end
                2'b01: begin
                    pllMem[pllPtr] = mdwdi;
                    cntWr++;
                end
                default: begin
                    pllRdo = pllMem[pllPtr];
                    cntRd++;
                end
            endcase
        end
    end

    // One comparison: count it, report it when it differs.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // MDRP fields must hold across the low phase and the high phase, and
    // the high phase must last CLK_DIV clk cycles.
    task automatic monitorSample();
        logic [10:0] cur;
        cur = {mdopc, mdainc, mdwdi};
        if (!skipMon) begin
            if (mdclk && !pClk1) begin
                checkOutput("stableLow1", 32'(cur), 32'(pVal1));
                checkOutput("stableLow2", 32'(cur), 32'(pVal2));
            end
            if (!mdclk && pClk1) begin
                checkOutput("stableHigh", 32'(pVal1), 32'(pVal2));
                checkOutput("highPhase", 32'(highRun), 32'(CLK_DIV));
            end
        end
        highRun = mdclk ? highRun + 1 : 0;
        pVal2   = pVal1;
        pVal1   = cur;
        pClk1   = mdclk;
    endtask

    // Advance one clk and sample away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        monitorSample();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".ready"}, 32'(cmd_ready), 32'd0);
        checkOutput({tag, ".rspValid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, ".rdata"}, 32'(rsp_rdata), 32'd0);
        checkOutput({tag, ".mdclk"}, 32'(mdclk), 32'd0);
        checkOutput({tag, ".mdopc"}, 32'(mdopc), 32'd0);
        checkOutput({tag, ".mdainc"}, 32'(mdainc), 32'd0);
        checkOutput({tag, ".mdwdi"}, 32'(mdwdi), 32'd0);
    endtask

    // One complete host transaction. With junk set, cmd_valid stays high
    // while busy and the command fields are scrambled every cycle.
    task automatic applyStimulus(input logic wr, input logic [6:0] addr,
                                 input logic [7:0] wd, input logic junk);
        logic       arstExp;
        logic [6:0] startPtr;
        logic [7:0] rdExp;
        int         incExp;
        int         nExp;
        int         latExp;
        int         lat;
        int         a0, i0, w0, r0, n0;

        arstExp  = !refPtrOk || (addr < refPtr);
        startPtr = arstExp ? 7'd0 : refPtr;
        incExp   = int'(addr) - int'(startPtr);
        nExp     = (arstExp ? 1 : 0) + incExp + (wr ? 1 : 2);
        latExp   = 1 + nExp * 2 * CLK_DIV;

        for (int w = 0; w < 50 && !cmd_ready; w++) tick();
        checkOutput("readyBeforeReq", 32'(cmd_ready), 32'd1);

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        a0 = cntArst;
        i0 = cntAinc;
        w0 = cntWr;
        r0 = cntRd;
        n0 = cntNop;
        tick();

        lat = 0;
        for (int k = 1; k <= 1200; k++) begin
            if (junk) begin
                cmd_valid = 1'b1;
                cmd_write = 1'($urandom);
                cmd_addr  = 7'($urandom);
                cmd_wdata = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (k == 1) checkOutput("busyNotReady", 32'(cmd_ready), 32'd0);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        cmd_valid = 1'b0;

        rdExp = wr ? 8'h00 : refMem[addr];
        checkOutput("latency", 32'(lat), 32'(latExp));
        checkOutput("rdata", 32'(rsp_rdata), 32'(rdExp));
        checkOutput("nArst", 32'(cntArst - a0), 32'(arstExp ? 1 : 0));
        checkOutput("nAinc", 32'(cntAinc - i0), 32'(incExp));
        checkOutput("nWrite", 32'(cntWr - w0), 32'(wr ? 1 : 0));
        checkOutput("nRead", 32'(cntRd - r0), 32'(wr ? 0 : 1));
        checkOutput("nNop", 32'(cntNop - n0), 32'(wr ? 0 : 1));
        checkOutput("idleMdclk", 32'(mdclk), 32'd0);
        checkOutput("idleMdopc", 32'(mdopc), 32'd0);
        checkOutput("idleMdainc", 32'(mdainc), 32'd0);
        if (wr) begin
            refMem[addr] = wd;
            checkOutput("pllReg", 32'(pllMem[addr]), 32'(wd));
        end
        refPtr   = addr;
        refPtrOk = 1'b1;

        tick();
        checkOutput("rspPulse", 32'(rsp_valid), 32'd0);
        checkOutput("rdataHeld", 32'(rsp_rdata), 32'(rdExp));
        checkOutput("readyBack", 32'(cmd_ready), 32'd1);
    endtask

    // Start a long write, then pull resetn low for one clk while the
    // controller is stepping the pointer.
    task automatic resetMidAinc();
        for (int w = 0; w < 50 && !cmd_ready; w++) tick();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 7'd10;
        cmd_wdata = 8'hAA;
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        skipMon = 1'b1;
        resetn  = 1'b0;
        tick();
        checkReset("abortReset");
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("noRspAfterAbort", 32'(rsp_valid), 32'd0);
        end
        checkOutput("pllReg10Untouched", 32'(pllMem[10]), 32'(refMem[10]));
        refPtrOk = 1'b0;
        skipMon  = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 128; a++) refMem[a] = initVal(7'(a));
        refPtr    = 7'd0;
        refPtrOk  = 1'b0;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 7'd0;
        cmd_wdata = 8'h00;

        repeat (3) tick();
        checkReset("powerOnReset");
        resetn = 1'b1;
        tick();
        checkOutput("readyAfterReset", 32'(cmd_ready), 32'd1);
        repeat (2) tick();
        skipMon = 1'b0;

        $display("[TB] directed sequence");
        applyStimulus(1'b1, 7'd3, 8'h5A, 1'b0);
        applyStimulus(1'b0, 7'd3, 8'h00, 1'b0);
        applyStimulus(1'b0, 7'd5, 8'h00, 1'b0);
        applyStimulus(1'b1, 7'd1, 8'h11, 1'b0);
        checkOutput("pllReg5Kept", 32'(pllMem[5]), 32'h000000C3);

        resetMidAinc();
        applyStimulus(1'b1, 7'd0, 8'h77, 1'b0);
        applyStimulus(1'b0, 7'd127, 8'h00, 1'b1);
        applyStimulus(1'b0, 7'd0, 8'h00, 1'b1);

        $display("[TB] randomized sequence");
        for (int t = 0; t < 30; t++) begin
            applyStimulus(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                          8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
